// File: rtl/route_compute.sv
`default_nettype none
// ============================================================================
//  Module      : route_compute
//  Description : Route-computation stage for a router in the chiplet mesh.
//                From the current and destination coordinates it selects one
//                output port. The on-tile mesh ports (cardinal and diagonal)
//                are used when the destination is in the same tile. The
//                SerDes ports are used otherwise. It then applies the VC-class
//                restriction and a single-alternate fallback on link status.
//                The result is registered one cycle after the request.
//
//  Ports       : clk, rst_n                clock, async active-low reset
//                pkt_valid                 header present this cycle
//                curr_tile_x/y, curr_lx/ly this router's coordinates
//                dest_tile_x/y, dest_lx/ly destination coordinates
//                vc_class                  VC class (bit0 = on-chiplet only)
//                link_up                   per-port usable mask
//                req_ports                 one-hot (or zero) port request
//                retry                     no usable port, hold and retry
//                route_valid               outputs belong to a sampled header
//
//  Revision    : 1.0 - initial release
// ============================================================================
module route_compute #(
    parameter int TILE_BITS  = 16,
    parameter int LOCAL_BITS = 2,
    parameter int N_PORTS    = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_valid,
    input  logic [TILE_BITS-1:0]  curr_tile_x,
    input  logic [TILE_BITS-1:0]  curr_tile_y,
    input  logic [LOCAL_BITS-1:0] curr_lx,
    input  logic [LOCAL_BITS-1:0] curr_ly,
    input  logic [TILE_BITS-1:0]  dest_tile_x,
    input  logic [TILE_BITS-1:0]  dest_tile_y,
    input  logic [LOCAL_BITS-1:0] dest_lx,
    input  logic [LOCAL_BITS-1:0] dest_ly,
    input  logic [1:0]            vc_class,
    input  logic [N_PORTS-1:0]    link_up,
    output logic [N_PORTS-1:0]    req_ports,
    output logic                  retry,
    output logic                  route_valid
);

    localparam int c_PW = $clog2(N_PORTS);

    localparam logic [c_PW-1:0] c_PORT_E     = c_PW'(0);
    localparam logic [c_PW-1:0] c_PORT_W     = c_PW'(1);
    localparam logic [c_PW-1:0] c_PORT_N     = c_PW'(2);
    localparam logic [c_PW-1:0] c_PORT_S     = c_PW'(3);
    localparam logic [c_PW-1:0] c_PORT_NE    = c_PW'(4);
    localparam logic [c_PW-1:0] c_PORT_NW    = c_PW'(5);
    localparam logic [c_PW-1:0] c_PORT_SE    = c_PW'(6);
    localparam logic [c_PW-1:0] c_PORT_SW    = c_PW'(7);
    localparam logic [c_PW-1:0] c_PORT_SER_E = c_PW'(8);
    localparam logic [c_PW-1:0] c_PORT_SER_W = c_PW'(9);
    localparam logic [c_PW-1:0] c_PORT_SER_N = c_PW'(10);
    localparam logic [c_PW-1:0] c_PORT_SER_S = c_PW'(11);
    localparam logic [c_PW-1:0] c_PORT_LOCAL = c_PW'(12);

    localparam logic [N_PORTS-1:0] c_ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

    logic            w_inter;
    logic            w_dx_pos;
    logic            w_dx_neg;
    logic            w_dy_pos;
    logic            w_dy_neg;
    logic [c_PW-1:0] w_primary;
    logic [c_PW-1:0] w_alt;
    logic            w_has_alt;
    logic [N_PORTS-1:0] w_req;
    logic            w_retry;

    assign w_inter  = (dest_tile_x != curr_tile_x) || (dest_tile_y != curr_tile_y);
    assign w_dx_pos = dest_lx > curr_lx;
    assign w_dx_neg = dest_lx < curr_lx;
    assign w_dy_pos = dest_ly > curr_ly;
    assign w_dy_neg = dest_ly < curr_ly;

    // Primary port. Between tiles the Y dimension is resolved first.
    always_comb begin
        w_primary = c_PORT_LOCAL;
        if (w_inter) begin
            if (dest_tile_y > curr_tile_y)      w_primary = c_PORT_SER_N;
            else if (dest_tile_y < curr_tile_y) w_primary = c_PORT_SER_S;
            else if (dest_tile_x > curr_tile_x) w_primary = c_PORT_SER_E;
            else                                w_primary = c_PORT_SER_W;
        end else begin
            case ({w_dy_pos, w_dy_neg, w_dx_pos, w_dx_neg})
                4'b1010: w_primary = c_PORT_NE;
                4'b1001: w_primary = c_PORT_NW;
                4'b0110: w_primary = c_PORT_SE;
                4'b0101: w_primary = c_PORT_SW;
                4'b0010: w_primary = c_PORT_E;
                4'b0001: w_primary = c_PORT_W;
                4'b1000: w_primary = c_PORT_N;
                4'b0100: w_primary = c_PORT_S;
                default: w_primary = c_PORT_LOCAL;
            endcase
        end
    end

    // Single alternate for each primary. The cardinal and SerDes rings rotate
    // counter-clockwise. Diagonals collapse onto their vertical component.
    always_comb begin
        w_alt     = c_PORT_LOCAL;
        w_has_alt = 1'b1;
        case (w_primary)
            c_PORT_E:     w_alt = c_PORT_N;
            c_PORT_N:     w_alt = c_PORT_W;
            c_PORT_W:     w_alt = c_PORT_S;
            c_PORT_S:     w_alt = c_PORT_E;
            c_PORT_SER_E: w_alt = c_PORT_SER_N;
            c_PORT_SER_N: w_alt = c_PORT_SER_W;
            c_PORT_SER_W: w_alt = c_PORT_SER_S;
            c_PORT_SER_S: w_alt = c_PORT_SER_E;
            c_PORT_NE:    w_alt = c_PORT_N;
            c_PORT_NW:    w_alt = c_PORT_N;
            c_PORT_SE:    w_alt = c_PORT_S;
            c_PORT_SW:    w_alt = c_PORT_S;
            default:      w_has_alt = 1'b0;
        endcase
    end

    // Final decision. An on-chiplet-only class never leaves the tile,
    // whatever the link status is.
    always_comb begin
        w_req   = '0;
        w_retry = 1'b0;
        if (w_inter && vc_class[0]) begin
            w_retry = 1'b1;
        end else if (link_up[w_primary]) begin
            w_req = c_ONE << w_primary;
        end else if (w_has_alt && link_up[w_alt]) begin
            w_req = c_ONE << w_alt;
        end else begin
            w_retry = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ports   <= '0;
            retry       <= 1'b0;
            route_valid <= 1'b0;
        end else begin
            route_valid <= pkt_valid;
            if (pkt_valid) begin
                req_ports <= w_req;
                retry     <= w_retry;
            end else begin
                req_ports <= '0;
                retry     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_route_compute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_route_compute
//  Description : Self-checking bench for route_compute. It runs directed
//                routing, fallback, VC and control steps, then randomized
//                headers that are compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_route_compute;

    localparam int TB = 16;
    localparam int LB = 2;
    localparam int NP = 13;

    localparam int P_E = 0, P_W = 1, P_N = 2, P_S = 3, P_NE = 4, P_NW = 5;
    localparam int P_SE = 6, P_SW = 7, P_SER_E = 8, P_SER_W = 9;
    localparam int P_SER_N = 10, P_SER_S = 11, P_LOCAL = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [TB-1:0] curr_tile_x = '0, curr_tile_y = '0;
    logic [LB-1:0] curr_lx = '0, curr_ly = '0;
    logic [TB-1:0] dest_tile_x = '0, dest_tile_y = '0;
    logic [LB-1:0] dest_lx = '0, dest_ly = '0;
    logic [1:0]    vc_class = '0;
    logic [NP-1:0] link_up = '1;
    logic [NP-1:0] req_ports;
    logic          retry;
    logic          route_valid;

    int total = 0;
    int bad   = 0;

    // Reference tables: port chosen by sign of (dy, dx), and the alternate port.
    int intra_tbl [3][3] = '{'{P_SW, P_S, P_SE}, '{P_W, P_LOCAL, P_E}, '{P_NW, P_N, P_NE}};
    int alt_tbl   [NP]   = '{P_N, P_S, P_W, P_E, P_N, P_N, P_S, P_S,
                             P_SER_N, P_SER_S, P_SER_W, P_SER_E, -1};

    route_compute #(.TILE_BITS(TB), .LOCAL_BITS(LB), .N_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid),
        .curr_tile_x(curr_tile_x), .curr_tile_y(curr_tile_y),
        .curr_lx(curr_lx), .curr_ly(curr_ly),
        .dest_tile_x(dest_tile_x), .dest_tile_y(dest_tile_y),
        .dest_lx(dest_lx), .dest_ly(dest_ly),
        .vc_class(vc_class), .link_up(link_up),
        .req_ports(req_ports), .retry(retry), .route_valid(route_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic int sgn(input int a, input int b);
        return (a > b) ? 1 : ((a < b) ? -1 : 0);
    endfunction

    // Behavioural model of the routing decision for one valid header.
    task automatic model(output logic [NP-1:0] req, output logic rty);
        int  p, a;
        bit  inter;
        inter = (dest_tile_x != curr_tile_x) || (dest_tile_y != curr_tile_y);
        if (inter) begin
            if (dest_tile_y != curr_tile_y)
                p = (dest_tile_y > curr_tile_y) ? P_SER_N : P_SER_S;
            else
                p = (dest_tile_x > curr_tile_x) ? P_SER_E : P_SER_W;
        end else begin
            p = intra_tbl[sgn(int'(dest_ly), int'(curr_ly)) + 1][sgn(int'(dest_lx), int'(curr_lx)) + 1];
        end
        req = '0;
        rty = 1'b0;
        if (inter && vc_class[0]) rty = 1'b1;
        else if (link_up[p]) req = oh(p);
        else begin
            a = alt_tbl[p];
            if (a >= 0 && link_up[a]) req = oh(a);
            else rty = 1'b1;
        end
    endtask

    task automatic hdr(input int ctx, input int cty, input int clx, input int cly,
                       input int dtx, input int dty, input int dlx, input int dly,
                       input logic [1:0] vc, input logic [NP-1:0] lu);
        @(negedge clk);
        pkt_valid   = 1'b1;
        curr_tile_x = TB'(ctx); curr_tile_y = TB'(cty);
        curr_lx     = LB'(clx); curr_ly     = LB'(cly);
        dest_tile_x = TB'(dtx); dest_tile_y = TB'(dty);
        dest_lx     = LB'(dlx); dest_ly     = LB'(dly);
        vc_class    = vc;
        link_up     = lu;
    endtask

    // Drive one header, then check the registered result one cycle later.
    task automatic step(input string tag, input int ctx, input int cty, input int clx, input int cly,
                        input int dtx, input int dty, input int dlx, input int dly,
                        input logic [1:0] vc, input logic [NP-1:0] lu,
                        input logic [NP-1:0] exp_req, input logic exp_rty);
        hdr(ctx, cty, clx, cly, dtx, dty, dlx, dly, vc, lu);
        @(posedge clk); #1;
        chk({tag, ".req"}, 32'(req_ports), 32'(exp_req));
        chk({tag, ".retry"}, 32'(retry), 32'(exp_rty));
        chk({tag, ".valid"}, 32'(route_valid), 32'd1);
    endtask

    initial begin
        logic [NP-1:0] all_up, m_req;
        logic          m_rty;
        all_up = '1;

        // Reset state
        #2;
        chk("reset.req", 32'(req_ports), 32'd0);
        chk("reset.retry", 32'(retry), 32'd0);
        chk("reset.valid", 32'(route_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle.valid", 32'(route_valid), 32'd0);

        // Intra-tile directions from local (1,1)
        step("intra_e",  0,0,1,1, 0,0,2,1, 2'b00, all_up, oh(P_E),  1'b0);
        step("intra_w",  0,0,1,1, 0,0,0,1, 2'b00, all_up, oh(P_W),  1'b0);
        step("intra_n",  0,0,1,1, 0,0,1,2, 2'b00, all_up, oh(P_N),  1'b0);
        step("intra_s",  0,0,1,1, 0,0,1,0, 2'b00, all_up, oh(P_S),  1'b0);
        step("intra_ne", 0,0,1,1, 0,0,2,2, 2'b00, all_up, oh(P_NE), 1'b0);
        step("intra_nw", 0,0,1,1, 0,0,0,2, 2'b00, all_up, oh(P_NW), 1'b0);
        step("intra_se", 0,0,1,1, 0,0,2,0, 2'b00, all_up, oh(P_SE), 1'b0);
        step("intra_sw", 0,0,1,1, 0,0,0,0, 2'b00, all_up, oh(P_SW), 1'b0);
        step("local",    3,2,1,1, 3,2,1,1, 2'b00, all_up, oh(P_LOCAL), 1'b0);

        // Inter-tile, Y resolved first
        step("ser_e", 1,1,1,1, 2,1,1,1, 2'b00, all_up, oh(P_SER_E), 1'b0);
        step("ser_w", 1,1,1,1, 0,1,1,1, 2'b00, all_up, oh(P_SER_W), 1'b0);
        step("ser_n", 1,1,1,1, 1,2,1,1, 2'b00, all_up, oh(P_SER_N), 1'b0);
        step("ser_s", 1,1,1,1, 0,0,1,1, 2'b00, all_up, oh(P_SER_S), 1'b0);
        step("ser_max", 0,0,0,0, 65535,0,3,3, 2'b10, all_up, oh(P_SER_E), 1'b0);

        // VC restriction
        step("vc_inter", 0,0,1,1, 1,0,1,1, 2'b01, all_up, '0, 1'b1);
        step("vc_intra", 0,0,1,1, 0,0,2,1, 2'b11, all_up, oh(P_E), 1'b0);

        // Fallback
        step("fb_e_n",   0,0,1,1, 0,0,2,1, 2'b00, all_up & ~oh(P_E), oh(P_N), 1'b0);
        step("fb_se_s",  0,0,1,1, 0,0,2,0, 2'b00, all_up & ~oh(P_SE), oh(P_S), 1'b0);
        step("fb_sere",  1,1,1,1, 2,1,1,1, 2'b00, all_up & ~oh(P_SER_E), oh(P_SER_N), 1'b0);
        step("fb_none",  1,1,1,1, 2,1,1,1, 2'b00, '0, '0, 1'b1);
        step("fb_local", 0,0,2,2, 0,0,2,2, 2'b00, all_up & ~oh(P_LOCAL), '0, 1'b1);

        // pkt_valid low clears outputs on the next edge
        @(negedge clk); pkt_valid = 1'b0;
        @(posedge clk); #1;
        chk("novalid.req", 32'(req_ports), 32'd0);
        chk("novalid.retry", 32'(retry), 32'd0);
        chk("novalid.valid", 32'(route_valid), 32'd0);

        // Asynchronous reset between edges
        step("pre_rst", 0,0,1,1, 0,0,2,1, 2'b00, all_up, oh(P_E), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.req", 32'(req_ports), 32'd0);
        chk("async_rst.valid", 32'(route_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1; pkt_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.valid", 32'(route_valid), 32'd0);
        step("post_rst", 0,0,1,1, 0,0,1,2, 2'b00, all_up, oh(P_N), 1'b0);

        // Randomized headers against the behavioural model
        for (int i = 0; i < 400; i++) begin
            logic [NP-1:0] lu;
            for (int b = 0; b < NP; b++) lu[b] = ($urandom_range(0, 3) != 0);
            hdr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), lu);
            model(m_req, m_rty);
            @(posedge clk); #1;
            chk("rand.req", 32'(req_ports), 32'(m_req));
            chk("rand.retry", 32'(retry), 32'(m_rty));
            chk("rand.valid", 32'(route_valid), 32'd1);
        end

        @(negedge clk); pkt_valid = 1'b0;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
